// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DIV_N = 8;
  localparam int unsigned DIV_M = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned M = DIV_M
) (
  input  logic [M:0]   rem_i,
  input  logic         bit_i,
  input  logic [M-1:0] divisor_i,
  output logic [M:0]   rem_c_o,
  output logic         qbit_c_o
);

  logic [M+1:0] shl;
  logic [M:0]   diff;

  // The difference is only kept when it is below the divisor, so M+1 bits suffice.
  always_comb begin
    shl      = {rem_i, bit_i};
    diff     = shl[M:0] - (M+1)'(divisor_i);
    qbit_c_o = (shl >= (M+2)'(divisor_i));
    rem_c_o  = qbit_c_o ? diff : shl[M:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, Start/Done handshake,
// results registered and held until the next completed operation.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DIV_N,
  parameter int unsigned M = DIV_M
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [M-1:0] Divisor,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Quotient,
  output logic [M-1:0] Remainder,
  output logic         DivByZero
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M:0]     prem_q, prem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [M:0]     step_rem;
  logic           step_qbit;

  div_step #(.M(M)) u_step (
    .rem_i     (prem_q),
    .bit_i     (shift_q[N-1]),
    .divisor_i (dvs_q),
    .rem_c_o   (step_rem),
    .qbit_c_o  (step_qbit)
  );

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next state; Start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = (Divisor == '0) ? FIN : RUN;
      RUN:     if (cnt_q == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; results load on the edge that enters FIN
  always_comb begin
    shift_d = shift_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = (state_d == RUN);
    done_d  = (state_d == FIN);
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Divisor != '0) begin
            shift_d = Dividend;
            dvs_d   = Divisor;
            prem_d  = '0;
            cnt_d   = CW'(N - 1);
          end else begin
            quo_d = '1;
            rem_d = Dividend[M-1:0];
            dbz_d = 1'b1;
          end
        end
      end
      RUN: begin
        shift_d = {shift_q[N-2:0], step_qbit};
        prem_d  = step_rem;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quo_d = {shift_q[N-2:0], step_qbit};
          rem_d = step_rem[M-1:0];
          dbz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: timestamp/arithmetic reference model checked every cycle,
// plus directed operations with literal expected results and latencies.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int unsigned N = DIV_N;
  localparam int unsigned M = DIV_M;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start = 1'b0;
  logic [N-1:0] Dividend = '0;
  logic [M-1:0] Divisor = '0;
  logic         Busy, Done, DivByZero;
  logic [N-1:0] Quotient;
  logic [M-1:0] Remainder;

  int vectors = 0;
  int miscompares = 0;

  seq_divider #(.N(N), .M(M)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation occupies fixed edge windows; values from / and %.
  int           edge_no = 0;
  int           avail = 0;
  int           bfrom = 0;
  int           bto = -1;
  int           dedge = -1;
  logic [N-1:0] pq = '0, mq = '0;
  logic [M-1:0] pr = '0, mr = '0;
  logic         pdz = 1'b0, mdz = 1'b0, mbusy = 1'b0, mdone = 1'b0;
  int           inv_dvd = 0, inv_dvs = 0;

  task automatic model_reset();
    avail = edge_no + 1;
    bfrom = 0;
    bto   = -1;
    dedge = -1;
    mq    = '0;
    mr    = '0;
    mdz   = 1'b0;
    mbusy = 1'b0;
    mdone = 1'b0;
  endtask

  always @(negedge Rst) model_reset();

  always @(posedge Clk) begin
    edge_no++;
    if (!Rst) begin
      model_reset();
    end else begin
      if (Start && edge_no >= avail) begin
        if (Divisor == '0) begin
          pq    = '1;
          pr    = Dividend[M-1:0];
          pdz   = 1'b1;
          bfrom = 0;
          bto   = -1;
          dedge = edge_no;
        end else begin
          pq    = Dividend / Divisor;
          pr    = M'(Dividend % Divisor);
          pdz   = 1'b0;
          bfrom = edge_no;
          bto   = edge_no + int'(N) - 1;
          dedge = edge_no + int'(N);
        end
        inv_dvd = int'(Dividend);
        inv_dvs = int'(Divisor);
        avail   = dedge + 2;
      end
      mbusy = (edge_no >= bfrom) && (edge_no <= bto);
      mdone = (edge_no == dedge);
      if (mdone) begin
        mq  = pq;
        mr  = pr;
        mdz = pdz;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    check("busy", Busy, mbusy);
    check("done", Done, mdone);
    check("quotient", Quotient, mq);
    check("remainder", Remainder, mr);
    check("divbyzero", DivByZero, mdz);
    if (mdone && Rst && inv_dvs != 0) begin
      check("invariant_qd_plus_r", int'(Quotient) * inv_dvs + int'(Remainder), inv_dvd);
      check("invariant_r_lt_d", longint'(int'(Remainder) < inv_dvs), 1);
    end
  end

  // Issue one operation at a negedge and wait (bounded) for Done; leaves the DUT in IDLE.
  task automatic do_op(input logic [N-1:0] a, input logic [M-1:0] b,
                       input logic [N-1:0] eq, input logic [M-1:0] er, input logic edz);
    int c;
    int bc;
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(negedge Clk);
    Start = 1'b0;
    c  = 1;
    bc = 0;
    while (!Done && c <= int'(N) + 3) begin
      if (Busy) bc++;
      @(negedge Clk);
      c++;
    end
    check("op_latency", c, (b == '0) ? 1 : int'(N) + 1);
    check("op_busy_cycles", bc, (b == '0) ? 0 : int'(N));
    check("op_quotient", Quotient, eq);
    check("op_remainder", Remainder, er);
    check("op_divbyzero", DivByZero, edz);
    @(negedge Clk);
  endtask

  initial begin
    int dn;
    int dc;
    logic [N-1:0] q;
    logic [M-1:0] r;
    int a;
    int b;

    Rst = 1'b1;
    #1 Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_quotient", Quotient, 0);
    check("reset_busy", Busy, 0);
    Rst = 1'b1;
    @(negedge Clk);

    do_op(8'd200, 4'd7,  8'd28,  4'd4,  1'b0);
    do_op(8'd255, 4'd1,  8'd255, 4'd0,  1'b0);
    do_op(8'd5,   4'd9,  8'd0,   4'd5,  1'b0);
    do_op(8'd0,   4'd3,  8'd0,   4'd0,  1'b0);
    do_op(8'd255, 4'd15, 8'd17,  4'd0,  1'b0);
    do_op(8'h3C,  4'd0,  8'hFF,  4'hC,  1'b1);
    do_op(8'd9,   4'd3,  8'd3,   4'd0,  1'b0);

    // Start pulse during RUN must be ignored
    Start    = 1'b1;
    Dividend = 8'd100;
    Divisor  = 4'd9;
    @(negedge Clk);
    dn = 0;
    dc = 0;
    q  = '0;
    r  = '0;
    for (int c = 1; c <= 20; c++) begin
      Start = (c == 4);
      if (c == 4) begin
        Dividend = 8'd50;
        Divisor  = 4'd5;
      end
      if (Done) begin
        dn++;
        dc = c;
        q  = Quotient;
        r  = Remainder;
      end
      @(negedge Clk);
    end
    check("ignored_start_done_count", dn, 1);
    check("ignored_start_latency", dc, int'(N) + 1);
    check("ignored_start_quotient", q, 11);
    check("ignored_start_remainder", r, 1);

    // Asynchronous reset in the middle of an operation
    Start    = 1'b1;
    Dividend = 8'd200;
    Divisor  = 4'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("async_reset_busy", Busy, 0);
    check("async_reset_done", Done, 0);
    check("async_reset_quotient", Quotient, 0);
    check("async_reset_remainder", Remainder, 0);
    check("async_reset_divbyzero", DivByZero, 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    dn = 0;
    for (int c = 0; c < 14; c++) begin
      if (Done) dn++;
      @(negedge Clk);
    end
    check("no_done_after_abort", dn, 0);
    do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);

    // Back-to-back random operations
    for (int i = 0; i < 500; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 15));
      do_op(N'(a), M'(b), N'(a / b), M'(a % b), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
